hex_to_sseg_decoder: RTL and testbench

Registered hexadecimal-to-seven-segment decoder. It converts one 4-bit hex digit plus a decimal-point bit into the 8-bit segment pattern for a common-anode seven-segment digit. It is one digit slice of the display path. Four instances feed the time-multiplexing display driver `disp_mux`: two show a switch byte and two show that byte incremented.

---
 rtl/sseg_pkg.sv | 28 ++
 rtl/hex_to_sseg_decoder_if.sv | 9 +
 rtl/hex_to_sseg_decoder.sv | 33 +++
 tb/tb_hex_to_sseg_decoder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment constants and the hex lookup used by every digit slice
// and by the display multiplexer.
package sseg_pkg;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [7:0] SSEG_OFF_AL = 8'hFF;

    // Unknown digits fall to the default branch and show a dark digit in
    // simulation instead of aliasing onto a valid table entry.
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: s = SEG_TABLE[h];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_sseg_decoder_if.sv
// Digit-slice bus: hex digit and decimal point in, registered segment word out.
interface hex_to_sseg_decoder_if;
    logic [3:0] hex;
    logic       dp;
    logic [7:0] sseg;

    modport master (output hex, output dp, input  sseg);
    modport slave  (input  hex, input  dp, output sseg);
endinterface

// File: rtl/hex_to_sseg_decoder.sv
// Registered hex-to-seven-segment decoder for one digit, selectable output
// polarity (common anode when ACTIVE_LOW=1, common cathode otherwise).
module hex_to_sseg_decoder
    import sseg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hex_to_sseg_decoder_if.slave   bus
);

    localparam logic [7:0] RESET_WORD = ACTIVE_LOW ? SSEG_OFF_AL : ~SSEG_OFF_AL;

    logic [7:0] seg;
    logic [7:0] seg_pol;

    always_comb begin
        seg     = {bus.dp, hex2seg(bus.hex)};
        seg_pol = ACTIVE_LOW ? seg : ~seg;
    end

    // NOTE: non-blocking assignment keeps the register update race-free against
    // any other process that samples sseg on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sseg <= RESET_WORD;
        end else begin
            bus.sseg <= seg_pol;
        end
    end

endmodule

// File: tb/tb_hex_to_sseg_decoder.sv
// Self-checking bench: both polarities driven in parallel and compared each
// cycle against a segment-name model, plus hand-computed literal expectations.
module tb_hex_to_sseg_decoder;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic cmp_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    hex_to_sseg_decoder_if bus_al1 ();
    hex_to_sseg_decoder_if bus_al0 ();

    hex_to_sseg_decoder #(.ACTIVE_LOW(1'b1)) dut_al1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_al1.slave)
    );

    hex_to_sseg_decoder #(.ACTIVE_LOW(1'b0)) dut_al0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_al0.slave)
    );

    always #5 clk = ~clk;

    // Lit segments per digit, by segment name.
    string lit_segs [16] = '{
        "abcdef", "bc",    "abdeg", "abcdg",
        "bcfg",   "acdfg", "acdefg","abc",
        "abcdefg","abcdfg","abcefg","cdefg",
        "adef",   "bcdeg", "adefg", "aefg"
    };

    // Common-anode word: a lit segment is 0, bit 6 = a ... bit 0 = g.
    function automatic logic [7:0] model_word(input logic [3:0] h, input logic d);
        logic [6:0] s;
        string      lit;
        int         k;
        s   = 7'h7F;
        lit = lit_segs[h];
        for (int i = 0; i < lit.len(); i++) begin
            k = int'(lit[i]) - 97;
            s[6 - k] = 1'b0;
        end
        return {d, s};
    endfunction

    // Expected common-anode output: one-cycle latency, asynchronous dark reset.
    logic [7:0] exp_al1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) exp_al1 <= 8'hFF;
        else          exp_al1 <= model_word(bus_al1.hex, bus_al1.dp);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_al1", bus_al1.sseg, exp_al1);
            check("cycle_al0", bus_al0.sseg, ~exp_al1);
        end
    end

    task automatic drive(input logic [3:0] h, input logic d);
        @(posedge clk);
        #1;
        bus_al1.hex = h; bus_al1.dp = d;
        bus_al0.hex = h; bus_al0.dp = d;
    endtask

    // Sample one cycle after drive(), away from the edge.
    task automatic expect_next(input string name, input logic [7:0] al1, input logic [7:0] al0);
        @(posedge clk);
        #2;
        check({name, "_al1"}, bus_al1.sseg, al1);
        check({name, "_al0"}, bus_al0.sseg, al0);
    endtask

    initial begin
        bus_al1.hex = 4'h0; bus_al1.dp = 1'b0;
        bus_al0.hex = 4'h0; bus_al0.dp = 1'b0;

        // Model pinned against hand-decoded words.
        check("model_8",    model_word(4'h8, 1'b0), 8'h00);
        check("model_C",    model_word(4'hC, 1'b0), 8'h31);
        check("model_d_dp", model_word(4'hD, 1'b1), 8'hC2);
        check("model_F",    model_word(4'hF, 1'b0), 8'h38);

        // Inputs toggle while reset is held: output stays dark.
        @(posedge clk);
        cmp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        #2;
        check("reset_hold_al1", bus_al1.sseg, 8'hFF);
        check("reset_hold_al0", bus_al0.sseg, 8'h00);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Full sweep on consecutive cycles, dp off.
        for (int h = 0; h < 16; h++) drive(4'(h), 1'b0);

        drive(4'h8, 1'b0); expect_next("hex8",   8'h00, 8'hFF);
        drive(4'hC, 1'b0); expect_next("hexC",   8'h31, 8'hCE);
        drive(4'h2, 1'b0); expect_next("hi2",    8'h12, 8'hED);
        drive(4'hD, 1'b1); expect_next("inc_D",  8'hC2, 8'h3D);
        drive(4'h2, 1'b1); expect_next("inc_2",  8'h92, 8'h6D);
        drive(4'hF, 1'b0); expect_next("carryF", 8'h38, 8'hC7);
        drive(4'h0, 1'b1); expect_next("carry0", 8'h81, 8'h7E);
        drive(4'h1, 1'b0); expect_next("dp_off", 8'h4F, 8'hB0);
        drive(4'h1, 1'b1); expect_next("dp_on",  8'hCF, 8'h30);
        drive(4'h1, 1'b0); expect_next("dp_off2",8'h4F, 8'hB0);

        // Reset asserted mid-cycle must clear the output without a clock edge.
        drive(4'h5, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_al1", bus_al1.sseg, 8'hFF);
        check("async_rst_al0", bus_al0.sseg, 8'h00);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) begin
                #1 reset_n = 1'b0;
                @(negedge clk);
                #1 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
